// File: rtl/omnivision_spi_pkg.sv
// Shared definitions for the Omnivision custom SPI transmitter and receiver.
package omnivision_spi_pkg;

  localparam logic [7:0]  OV_MODE_RAW8 = 8'h2A;
  localparam logic [15:0] OV_SYNC      = 16'hFFFF;

  // Frame sequencer states, shared so tx and rx agree on naming.
  typedef logic [2:0] ov_state_t;
  localparam ov_state_t OV_IDLE = 3'd0;
  localparam ov_state_t OV_HDR  = 3'd1;
  localparam ov_state_t OV_DIM  = 3'd2;
  localparam ov_state_t OV_PIX  = 3'd3;
  localparam ov_state_t OV_GAP  = 3'd4;

  // Header word: mode byte, reserved zero byte, then the sync pattern.
  function automatic logic [31:0] ov_hdr_word(input logic [7:0] mode);
    return {mode, 8'h00, OV_SYNC};
  endfunction

  // Dimension word: rows in the upper half, cols in the lower half.
  function automatic logic [31:0] ov_dim_word(input logic [15:0] rows,
                                              input logic [15:0] cols);
    return {rows, cols};
  endfunction

endpackage

// File: rtl/omnivision_spi_tx.sv
// Omnivision custom SPI serializer: header, dimensions, pixels, idle gap.
// One shift register holds the current word or pixel; a beat counter tracks
// which slice is on sdat and triggers the next load on the final beat.
module omnivision_spi_tx
  import omnivision_spi_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         SPI_WIDTH  = 2,
  parameter int         DIM_WIDTH  = 12,
  parameter logic [7:0] MODE       = OV_MODE_RAW8,
  parameter int         IDLE_BEATS = 16
) (
  input  logic                  sclk,
  input  logic                  resetb,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  num_rows_in,
  input  logic [DIM_WIDTH-1:0]  num_cols_in,
  input  logic [DATA_WIDTH-1:0] pix_dat,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [SPI_WIDTH-1:0]  sdat,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  localparam int         SH_W      = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
  localparam int         CNT_W     = 2 * DIM_WIDTH;
  localparam logic [7:0] WORD_LAST = 8'(32 / SPI_WIDTH - 1);
  localparam logic [7:0] PIX_LAST  = 8'(DATA_WIDTH / SPI_WIDTH - 1);
  localparam logic [15:0] GAP_LAST = 16'(IDLE_BEATS - 1);

  ov_state_t              state_reg;
  logic [7:0]             beat_reg;
  logic [15:0]            gap_reg;
  logic [SH_W-1:0]        sh_reg;
  logic [SPI_WIDTH-1:0]   sdat_reg;
  logic [DIM_WIDTH-1:0]   rows_reg;
  logic [DIM_WIDTH-1:0]   cols_reg;
  logic [CNT_W-1:0]       total_reg;
  logic [CNT_W-1:0]       sent_reg;
  logic                   done_reg;
  logic                   underrun_reg;

  logic                   word_last;
  logic                   pix_last;
  logic                   pix_slot;
  logic [SH_W-1:0]        hdr_word;
  logic [SH_W-1:0]        dim_word;
  logic [SH_W-1:0]        pix_word;

  // Slot decode and the words that can be loaded into the shifter.
  always_comb begin
    word_last = (beat_reg == WORD_LAST);
    pix_last  = (beat_reg == PIX_LAST);
    // A slot opens on the final beat of DIM or of a pixel while pixels remain;
    // in DIM sent_reg is still zero so this also covers the empty-frame case.
    pix_slot  = (((state_reg == OV_DIM) && word_last) ||
                 ((state_reg == OV_PIX) && pix_last)) && (sent_reg < total_reg);
    hdr_word  = SH_W'(ov_hdr_word(MODE));
    dim_word  = SH_W'(ov_dim_word(16'(rows_reg), 16'(cols_reg)));
    // A missed slot still consumes a pixel position, sent as zero.
    pix_word  = pix_valid ? SH_W'(pix_dat) : '0;
  end

  // Frame sequencer, shifter and status pulses.
  always_ff @(posedge sclk or negedge resetb) begin
    if (!resetb) begin
      state_reg    <= OV_IDLE;
      beat_reg     <= '0;
      gap_reg      <= '0;
      sh_reg       <= '0;
      sdat_reg     <= '0;
      rows_reg     <= '0;
      cols_reg     <= '0;
      total_reg    <= '0;
      sent_reg     <= '0;
      done_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      underrun_reg <= 1'b0;
      case (state_reg)
        OV_IDLE: begin
          sdat_reg <= '0;
          if (start) begin
            rows_reg  <= num_rows_in;
            cols_reg  <= num_cols_in;
            total_reg <= CNT_W'(num_rows_in) * CNT_W'(num_cols_in);
            sent_reg  <= '0;
            sdat_reg  <= hdr_word[SPI_WIDTH-1:0];
            sh_reg    <= hdr_word >> SPI_WIDTH;
            beat_reg  <= '0;
            state_reg <= OV_HDR;
          end
        end
        OV_HDR: begin
          if (word_last) begin
            sdat_reg  <= dim_word[SPI_WIDTH-1:0];
            sh_reg    <= dim_word >> SPI_WIDTH;
            beat_reg  <= '0;
            state_reg <= OV_DIM;
          end else begin
            sdat_reg <= sh_reg[SPI_WIDTH-1:0];
            sh_reg   <= sh_reg >> SPI_WIDTH;
            beat_reg <= beat_reg + 8'd1;
          end
        end
        OV_DIM, OV_PIX: begin
          if (pix_slot) begin
            sdat_reg     <= pix_word[SPI_WIDTH-1:0];
            sh_reg       <= pix_word >> SPI_WIDTH;
            beat_reg     <= '0;
            sent_reg     <= sent_reg + 1'b1;
            underrun_reg <= ~pix_valid;
            state_reg    <= OV_PIX;
          end else if ((state_reg == OV_DIM) ? word_last : pix_last) begin
            sdat_reg  <= '0;
            gap_reg   <= '0;
            done_reg  <= 1'b1;
            state_reg <= OV_GAP;
          end else begin
            sdat_reg <= sh_reg[SPI_WIDTH-1:0];
            sh_reg   <= sh_reg >> SPI_WIDTH;
            beat_reg <= beat_reg + 8'd1;
          end
        end
        OV_GAP: begin
          sdat_reg <= '0;
          if (gap_reg == GAP_LAST) begin
            state_reg <= OV_IDLE;
          end else begin
            gap_reg <= gap_reg + 16'd1;
          end
        end
        default: begin
          sdat_reg  <= '0;
          state_reg <= OV_IDLE;
        end
      endcase
    end
  end

  assign pix_ready = pix_slot;
  assign sdat      = sdat_reg;
  assign busy      = (state_reg != OV_IDLE);
  assign done      = done_reg;
  assign underrun  = underrun_reg;

endmodule

// File: tb/tb_omnivision_spi_tx.sv
// Scoreboard bench for omnivision_spi_tx: the driver builds the expected
// per-cycle frame image from the framing rules, a monitor compares each cycle.
module tb_omnivision_spi_tx;

  localparam int SW   = 2;
  localparam int DW   = 8;
  localparam int DIMW = 12;
  localparam int IDLE = 16;
  localparam int WB   = 32 / SW;   // beats per 32-bit word
  localparam int PB   = DW / SW;   // beats per pixel
  localparam logic [31:0] HDR_W = {8'h2A, 8'h00, 8'hFF, 8'hFF};

  typedef struct packed {
    logic [SW-1:0] sdat;
    logic          busy;
    logic          done;
    logic          und;
    logic          rdy;
  } rec_t;

  logic            sclk = 1'b0;
  logic            resetb = 1'b0;
  logic            start = 1'b0;
  logic [DIMW-1:0] num_rows_in = '0;
  logic [DIMW-1:0] num_cols_in = '0;
  logic [DW-1:0]   pix_dat = '0;
  logic            pix_valid = 1'b0;
  logic            pix_ready;
  logic [SW-1:0]   sdat;
  logic            busy;
  logic            done;
  logic            underrun;

  int total = 0;
  int bad   = 0;

  rec_t          exp_q[$];
  logic [DW-1:0] px_data[$];
  bit            px_val[$];
  int            px_idx = 0;

  omnivision_spi_tx #(
    .DATA_WIDTH(DW), .SPI_WIDTH(SW), .DIM_WIDTH(DIMW),
    .MODE(8'h2A), .IDLE_BEATS(IDLE)
  ) dut (
    .sclk(sclk), .resetb(resetb), .start(start),
    .num_rows_in(num_rows_in), .num_cols_in(num_cols_in),
    .pix_dat(pix_dat), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .sdat(sdat), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 sclk = ~sclk;

  task automatic drive_pix();
    if (px_idx < px_data.size() && px_val[px_idx]) begin
      pix_valid = 1'b1;
      pix_dat   = px_data[px_idx];
    end else begin
      pix_valid = 1'b0;
      pix_dat   = DW'($urandom);
    end
  endtask

  // Pixel source: a slot seen at the falling edge is consumed at the next rising edge.
  initial begin
    forever begin
      @(negedge sclk);
      if (pix_ready) begin
        @(posedge sclk);
        #1;
        px_idx++;
        drive_pix();
      end
    end
  end

  // Monitor: one comparison per cycle against the scoreboard, or idle when empty.
  initial begin
    rec_t e;
    rec_t a;
    int   n;
    n = 0;
    forever begin
      @(negedge sclk);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '0;
      a = {sdat, busy, done, underrun, pix_ready};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle_check #%0d: got sdat=%0d busy=%0b done=%0b underrun=%0b pix_ready=%0b, want sdat=%0d busy=%0b done=%0b underrun=%0b pix_ready=%0b",
                 n, a.sdat, a.busy, a.done, a.und, a.rdy, e.sdat, e.busy, e.done, e.und, e.rdy);
      end
      n++;
    end
  end

  // Reference model: expected per-cycle record from the framing rules.
  task automatic build_frame(input int rows, input int cols);
    int          n;
    int          len;
    logic [31:0] dimw;
    logic [31:0] w;
    rec_t        r;
    n    = rows * cols;
    len  = 2 * WB + n * PB;
    dimw = {16'(rows), 16'(cols)};
    for (int c = 0; c <= len + IDLE; c++) begin
      r = '0;
      r.busy = (c < len + IDLE);
      r.done = (c == len);
      if (c < WB) begin
        w = HDR_W >> (c * SW);
        r.sdat = w[SW-1:0];
      end else if (c < 2 * WB) begin
        w = dimw >> ((c - WB) * SW);
        r.sdat = w[SW-1:0];
        r.rdy  = (c == 2 * WB - 1) && (n > 0);
      end else if (c < len) begin
        int p;
        int k;
        p = (c - 2 * WB) / PB;
        k = (c - 2 * WB) % PB;
        w = px_val[p] ? 32'(px_data[p]) : 32'd0;
        w = w >> (k * SW);
        r.sdat = w[SW-1:0];
        r.und  = (k == 0) && !px_val[p];
        r.rdy  = (k == PB - 1) && (p < n - 1);
      end
      exp_q.push_back(r);
    end
    $display("frame rows=%0d cols=%0d pixels=%0d beats=%0d", rows, cols, n, len);
  endtask

  task automatic fill_pixels(input int n, input int pct_invalid);
    px_data.delete();
    px_val.delete();
    for (int i = 0; i < n; i++) begin
      px_data.push_back(DW'($urandom));
      px_val.push_back($urandom_range(99) >= pct_invalid);
    end
  endtask

  // Issue a frame request from a point #1 after a rising edge.
  task automatic issue_frame(input int rows, input int cols);
    px_idx = 0;
    drive_pix();
    num_rows_in = DIMW'(rows);
    num_cols_in = DIMW'(cols);
    start = 1'b1;
    @(posedge sclk);
    #1;
    start = 1'b0;
    num_rows_in = DIMW'($urandom);
    num_cols_in = DIMW'($urandom);
    build_frame(rows, cols);
  endtask

  task automatic drain();
    for (int i = 0; i < 5000 && exp_q.size() > 0; i++) @(posedge sclk);
    #1;
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d records left, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat ($urandom_range(3)) @(posedge sclk);
    #1;
  endtask

  task automatic run_frame(input int rows, input int cols, input bit poke);
    int len;
    int m;
    issue_frame(rows, cols);
    if (poke) begin
      len = 2 * WB + rows * cols * PB + IDLE;
      m = $urandom_range(len - 1, 1);
      repeat (m) @(posedge sclk);
      #1;
      num_rows_in = DIMW'($urandom_range(7));
      num_cols_in = DIMW'($urandom_range(7));
      start = 1'b1;
      @(posedge sclk);
      #1;
      start = 1'b0;
    end
    drain();
  endtask

  initial begin
    int r;
    int c;
    repeat (3) @(posedge sclk);
    #1;
    total++;
    if ({sdat, busy, done, underrun, pix_ready} !== '0) begin
      bad++;
      $display("FAIL reset_state: got sdat=%0d busy=%0b done=%0b underrun=%0b pix_ready=%0b, want all 0",
               sdat, busy, done, underrun, pix_ready);
    end
    resetb = 1'b1;
    repeat (2) @(posedge sclk);
    #1;

    // Reference frame: 2x3, pixels E4,1,2,3,4,5, all valid.
    px_data.delete();
    px_val.delete();
    px_data.push_back(8'hE4);
    for (int i = 1; i < 6; i++) px_data.push_back(DW'(i));
    for (int i = 0; i < 6; i++) px_val.push_back(1'b1);
    run_frame(2, 3, 1'b0);

    // Same frame with a start pulse mid-frame: must be identical.
    run_frame(2, 3, 1'b1);

    // Underrun on the third pixel.
    px_val[2] = 1'b0;
    run_frame(2, 3, 1'b0);

    // Empty frame: header and dimensions only.
    fill_pixels(0, 0);
    run_frame(0, 5, 1'b1);
    run_frame(4, 0, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 12; f++) begin
      r = $urandom_range(6);
      c = $urandom_range(6);
      fill_pixels(r * c, 20);
      run_frame(r, c, $urandom_range(1));
    end

    // Reset in the middle of the pixel phase.
    fill_pixels(12, 0);
    issue_frame(3, 4);
    repeat (40) @(posedge sclk);
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_before_reset: got %0b, want 1", busy);
    end
    exp_q.delete();
    resetb = 1'b0;
    #1;
    total++;
    if (sdat !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_frame: got sdat=%0d busy=%0b, want sdat=0 busy=0", sdat, busy);
    end
    repeat (3) @(posedge sclk);
    #1;
    resetb = 1'b1;
    repeat (4) @(posedge sclk);
    #1;

    // Clean frame after reset.
    fill_pixels(6, 10);
    run_frame(2, 3, 1'b0);

    repeat (2) @(posedge sclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
